ram256_arbiter: RTL
===================

Name: ram256_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 256 x 16 single-port RAM (ram256).
- Owns the RAM control pins: en, write, read, address, datain.
- Accepts one command at a time, issues it as a single-cycle RAM access, and returns read data or write completion to the winning requester.
- Sits between the two bus masters (port A, port B) and the RAM instance. The RAM is never driven with write and read together.

Parameters:
- AW, 8, RAM address width (256 locations).
- DW, 16, RAM data width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A command valid.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  A command accepted (1-cycle pulse).
- a_rvalid  out  1  A read data valid (1-cycle pulse).
- a_rdata  out  DW  A read data, held until A's next read completes.
- a_wdone  out  1  A write completed (1-cycle pulse).
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_wdone: same as the A ports, for requester B.
- ram_en  out  1  to RAM en.
- ram_write  out  1  to RAM write.
- ram_read  out  1  to RAM read.
- ram_address  out  AW  to RAM address.
- ram_datain  out  DW  to RAM datain.
- ram_dataout  in  DW  from RAM dataout (registered in RAM; valid the cycle after the RAM samples a read).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; rr_last=B, so A wins the first tie.
  - All gnt/rvalid/wdone/busy = 0; rdata = 0.
  - ram_en/write/read = 0; ram_address/ram_datain = 0.
  - An in-flight command is dropped with no response pulse.
- All outputs are registered.
- States: IDLE, ISSUE, CAPTURE.
- Acceptance:
  - Occurs at a clock edge where state is IDLE or CAPTURE and a_req|b_req=1.
  - Winner: the sole requester, or on a tie the one that is not rr_last.
  - Winner's we/addr/wdata are latched; rr_last is set to the winner; next state is ISSUE.
  - If no request, IDLE→IDLE and CAPTURE→IDLE.
- ISSUE (exactly 1 cycle):
  - Winner's gnt=1.
  - ram_en=1, ram_write=we, ram_read=!we.
  - ram_address/ram_datain come from the latched values.
  - Next state: CAPTURE.
- CAPTURE (exactly 1 cycle):
  - ram_en=ram_write=ram_read=0.
  - Acceptance logic is evaluated (back-to-back allowed).
  - At the edge leaving CAPTURE, for a read: winner's rdata <= ram_dataout, rvalid=1 for the next cycle. For a write: wdone=1 for the next cycle.
- Latency:
  - Request accepted at edge k: gnt high in cycle k..k+1; RAM samples at edge k+1.
  - rvalid/wdone high in cycle k+2..k+3.
- Throughput: one access per 2 cycles under continuous requests. A response pulse may coincide with the next gnt.
- Requester rule:
  - Hold req and fields stable until gnt is seen.
  - req still high in the cycle after gnt counts as a new command.
  - Fields changing while req is high and no gnt has been seen is illegal.
- Fairness: with both requesting continuously, grants alternate A,B,A,B. No requester waits more than one other access.
- Write data written to address X is visible to a read of X issued on the next ISSUE.
- ram_dataout is ignored outside CAPTURE, so RAM high-Z output while en=0 never propagates.
- Address wrap is not applicable: the full AW range is passed through, 0xFF is valid.
- Assertion (simulation): ram_write & ram_read never both 1; ram_en=0 implies both are 0.

Decomposition:
- Package ram256_arb_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2;
  - requester ID constants REQ_A=1'b0, REQ_B=1'b1;
  - AW/DW defaults.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: valid, winner.
  - Combinational; the pointer register lives in the parent.

Test Plan:
- Reset mid-ISSUE (A read in flight, rst_n low 1 cycle) -> ram_en=0 immediately, no a_rvalid, a_rdata=0, state IDLE.
- A writes 0xBEEF to addr 0x12, then A reads 0x12 -> a_gnt at cycle 1, ram_en=1/ram_write=1/ram_address=0x12 at cycle 1, a_wdone at cycle 3; read returns a_rdata=0xBEEF with a_rvalid 2 cycles after its a_gnt.
- a_req and b_req both held high for 8 accesses from reset -> grants A,B,A,B,A,B,A,B; a gnt every 2 cycles; never both gnt in one cycle.
- B writes 0x0001 to 0xFF, A reads 0xFF simultaneously (tie, rr_last=B) -> A wins, reads old content; B granted next; a second A read then returns 0x0001.
- Idle bus with ram_dataout forced to X/Z -> a_rvalid/b_rvalid stay 0, rdata unchanged, ram_en=0 throughout.
- b_req single-cycle pulse while A holds the RAM -> B granted immediately after A's CAPTURE; b_wdone 2 cycles after b_gnt; busy low only after the last CAPTURE.

Source files
------------

// File: rtl/ram256_arb_pkg.sv
// Shared types and constants for the ram256 two-requester arbiter.
// Imported by the interface, the picker and the top.
package ram256_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram256_arbiter_if.sv
// Requester and RAM-side signal bundle for ram256_arbiter.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface ram256_arbiter_if
  import ram256_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          a_wdone;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          b_wdone;

  logic          ram_en;
  logic          ram_write;
  logic          ram_read;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_datain;
  logic [DW-1:0] ram_dataout;

  logic          busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_wdone,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_wdone,
    output ram_en, ram_write, ram_read, ram_address, ram_datain,
    input  ram_dataout,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_wdone,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_wdone,
    input  ram_en, ram_write, ram_read, ram_address, ram_datain,
    output ram_dataout,
    input  busy
  );

endinterface

// File: rtl/ram256_arbiter_rr_arb2.sv
// Two-way round-robin picker; purely combinational, the last-winner pointer lives in the parent.
// req[0] is requester A, req[1] is requester B.
module rr_arb2
  import ram256_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    valid  = |req;
    winner = REQ_A;
    case (req)
      2'b01:   winner = REQ_A;
      2'b10:   winner = REQ_B;
      2'b11:   winner = ~last;
      default: winner = REQ_A;
    endcase
  end

endmodule

// File: rtl/ram256_arbiter.sv
// Round-robin arbiter and sequencer for the 256x16 single-port RAM.
// One command in flight at a time: ISSUE drives the RAM, CAPTURE returns the response.
module ram256_arbiter
  import ram256_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic             clk,
  input logic             rst_n,
  ram256_arbiter_if.slave bus
);

  state_t        state;
  logic          rr_last;
  logic          lat_who;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  logic          a_gnt_q, a_rvalid_q, a_wdone_q;
  logic          b_gnt_q, b_rvalid_q, b_wdone_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          ram_en_q, ram_write_q, ram_read_q;
  logic [AW-1:0] ram_address_q;
  logic [DW-1:0] ram_datain_q;
  logic          busy_q;

  logic          pick_valid;
  logic          pick_winner;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  rr_arb2 u_pick (
    .req    ({bus.b_req, bus.a_req}),
    .last   (rr_last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign win_we    = (pick_winner == REQ_B) ? bus.b_we    : bus.a_we;
  assign win_addr  = (pick_winner == REQ_B) ? bus.b_addr  : bus.a_addr;
  assign win_wdata = (pick_winner == REQ_B) ? bus.b_wdata : bus.a_wdata;

  // Pulses default low each cycle; CAPTURE both answers the current command and may accept the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_last       <= REQ_B;
      lat_who       <= REQ_A;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      a_gnt_q       <= 1'b0;
      a_rvalid_q    <= 1'b0;
      a_wdone_q     <= 1'b0;
      a_rdata_q     <= '0;
      b_gnt_q       <= 1'b0;
      b_rvalid_q    <= 1'b0;
      b_wdone_q     <= 1'b0;
      b_rdata_q     <= '0;
      ram_en_q      <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_read_q    <= 1'b0;
      ram_address_q <= '0;
      ram_datain_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_wdone_q   <= 1'b0;
      b_wdone_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_write_q <= 1'b0;
      ram_read_q  <= 1'b0;
      busy_q      <= 1'b0;

      // The RAM output is only trusted here, one cycle after it sampled the read.
      if (state == CAPTURE) begin
        if (lat_we) begin
          if (lat_who == REQ_A) a_wdone_q <= 1'b1;
          else                  b_wdone_q <= 1'b1;
        end else begin
          if (lat_who == REQ_A) begin
            a_rdata_q  <= bus.ram_dataout;
            a_rvalid_q <= 1'b1;
          end else begin
            b_rdata_q  <= bus.ram_dataout;
            b_rvalid_q <= 1'b1;
          end
        end
      end

      case (state)
        IDLE, CAPTURE: begin
          if (pick_valid) begin
            state         <= ISSUE;
            rr_last       <= pick_winner;
            lat_who       <= pick_winner;
            lat_we        <= win_we;
            lat_addr      <= win_addr;
            lat_wdata     <= win_wdata;
            a_gnt_q       <= (pick_winner == REQ_A);
            b_gnt_q       <= (pick_winner == REQ_B);
            ram_en_q      <= 1'b1;
            ram_write_q   <= win_we;
            ram_read_q    <= ~win_we;
            ram_address_q <= win_addr;
            ram_datain_q  <= win_wdata;
            busy_q        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state  <= CAPTURE;
          busy_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_gnt       = a_gnt_q;
  assign bus.a_rvalid    = a_rvalid_q;
  assign bus.a_rdata     = a_rdata_q;
  assign bus.a_wdone     = a_wdone_q;
  assign bus.b_gnt       = b_gnt_q;
  assign bus.b_rvalid    = b_rvalid_q;
  assign bus.b_rdata     = b_rdata_q;
  assign bus.b_wdone     = b_wdone_q;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_write   = ram_write_q;
  assign bus.ram_read    = ram_read_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_datain  = ram_datain_q;
  assign bus.busy        = busy_q;

  ram_ctrl_legal: assert property (@(posedge clk) disable iff (!rst_n)
    !(ram_write_q && ram_read_q) && (ram_en_q || !(ram_write_q || ram_read_q)));

endmodule
